// File: rtl/div_uu_sched.sv
// div_uu_sched: round-robin scheduler sharing one pipelined div_uu divider
// among NREQ requesters. A tag pipe matched to the divider latency carries
// the requester id of every in-flight operation. Results return in issue order.
// Optional feature macro: DIV_SCHED_PERF_EN adds issue/stall performance counters.
module div_uu_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned Z_WIDTH = 16,
  parameter int unsigned D_WIDTH = Z_WIDTH / 2,
  parameter int unsigned LATENCY = D_WIDTH + 3,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*Z_WIDTH-1:0]    req_z,
  input  logic [NREQ*D_WIDTH-1:0]    req_d,
  output logic                       div_ena,
  output logic [Z_WIDTH-1:0]         div_z,
  output logic [D_WIDTH-1:0]         div_d,
  input  logic [D_WIDTH-1:0]         div_q,
  input  logic [D_WIDTH-1:0]         div_s,
  input  logic                       div_div0,
  input  logic                       div_ovf,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [D_WIDTH-1:0]         rsp_q,
  output logic [D_WIDTH-1:0]         rsp_s,
  output logic                       rsp_div0,
  output logic                       rsp_ovf
`ifdef DIV_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  logic [LATENCY-1:0] r_tag_v;
  logic [IDW-1:0]     r_tag_id [LATENCY];
  logic [IDW-1:0]     r_rr;

  logic               w_stall;
  logic               w_grant;
  logic [IDW-1:0]     w_win;
  logic [31:0]        w_idx;
  logic [Z_WIDTH-1:0] w_z [NREQ];
  logic [D_WIDTH-1:0] w_d [NREQ];

  // Split the flat request buses into per-requester operands
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_z[gi] = req_z[gi*Z_WIDTH +: Z_WIDTH];
    assign w_d[gi] = req_d[gi*D_WIDTH +: D_WIDTH];
  end

  // A valid result at the tail that cannot retire freezes the whole pipe
  assign w_stall = r_tag_v[LATENCY-1] & ~rsp_ready;
  assign div_ena = ~w_stall;

  // Response channel is the tail of the tag pipe plus divider pass-through
  assign rsp_valid = r_tag_v[LATENCY-1];
  assign rsp_id    = r_tag_id[LATENCY-1];
  assign rsp_q     = div_q;
  assign rsp_s     = div_s;
  assign rsp_div0  = div_div0;
  assign rsp_ovf   = div_ovf;

  // Round-robin search from the pointer; no grant while stalled or in reset
  always_comb begin
    w_grant   = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    req_ready = '0;
    div_z     = '0;
    div_d     = '0;
    if (!rst && !w_stall) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_idx = (32'(r_rr) + 32'(k)) % NREQ;
        if (!w_grant && req_valid[IDW'(w_idx)]) begin
          w_grant = 1'b1;
          w_win   = IDW'(w_idx);
        end
      end
    end
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
      div_z            = w_z[w_win];
      div_d            = w_d[w_win];
    end
  end

  // Tag pipe advances in lockstep with the divider; pointer moves past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      r_rr    <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else if (!w_stall) begin
      r_tag_v     <= {r_tag_v[LATENCY-2:0], w_grant};
      r_tag_id[0] <= w_win;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_tag_id[i] <= r_tag_id[i-1];
      end
      if (w_grant) begin
        r_rr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
      end
    end
  end

`ifdef DIV_SCHED_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running wrap-around counters of grants and stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_div_uu_sched.sv
// Testbench for div_uu_sched: behavioural divider pipeline as the environment,
// scoreboard of expected responses with arrival times derived from grant time,
// latency and observed stall cycles.
module tb_div_uu_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned ZW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned LAT  = DW + 3;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] s;
    logic          div0;
    logic          ovf;
  } res_t;

  typedef struct {
    int   id;
    res_t r;
    int   arrive;
    int   stall_at;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*ZW-1:0]   req_z;
  logic [NREQ*DW-1:0]   req_d;
  logic                 div_ena;
  logic [ZW-1:0]        div_z;
  logic [DW-1:0]        div_d;
  logic [DW-1:0]        div_q;
  logic [DW-1:0]        div_s;
  logic                 div_div0;
  logic                 div_ovf;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_q;
  logic [DW-1:0]        rsp_s;
  logic                 rsp_div0;
  logic                 rsp_ovf;
`ifdef DIV_SCHED_PERF_EN
  logic [31:0]          perf_issue_cnt;
  logic [31:0]          perf_stall_cnt;
`endif

  logic [ZW-1:0] z_in [NREQ];
  logic [DW-1:0] d_in [NREQ];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rr_m     = 0;
  int stall_total = 0;
  int acc_cnt  = 0;
  exp_t exp_q [$];
  int grant_log [$];
  int acc_log [$];
  logic [IDW-1:0] last_id;
  logic [DW-1:0]  last_q, last_s;
  logic           last_div0, last_ovf;

  res_t pipe [LAT];

  div_uu_sched #(.NREQ(NREQ), .Z_WIDTH(ZW), .D_WIDTH(DW), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_z(req_z), .req_d(req_d),
    .div_ena(div_ena), .div_z(div_z), .div_d(div_d),
    .div_q(div_q), .div_s(div_s), .div_div0(div_div0), .div_ovf(div_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_s(rsp_s), .rsp_div0(rsp_div0), .rsp_ovf(rsp_ovf)
`ifdef DIV_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pack per-requester operands onto the flat buses
  always_comb begin
    req_z = '0;
    req_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_z[i*ZW +: ZW] = z_in[i];
      req_d[i*DW +: DW] = d_in[i];
    end
  end

  // Plain-arithmetic unsigned division with the divider's flag meanings
  function automatic res_t ref_div(input logic [ZW-1:0] z, input logic [DW-1:0] d);
    res_t r;
    int unsigned qq;
    r = '0;
    if (d == '0) begin
      r.div0 = 1'b1;
    end else begin
      qq    = int'(z) / int'(d);
      r.q   = DW'(qq);
      r.s   = DW'(int'(z) % int'(d));
      r.ovf = (qq > 255);
    end
    return r;
  endfunction

  // Environment divider: LAT-stage pipe advancing only with div_ena
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (div_ena) begin
      pipe[0] <= ref_div(div_z, div_d);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign div_q    = pipe[LAT-1].q;
  assign div_s    = pipe[LAT-1].s;
  assign div_div0 = pipe[LAT-1].div0;
  assign div_ovf  = pipe[LAT-1].ovf;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      z_in[i] = ZW'($urandom);
      d_in[i] = DW'($urandom);
    end
  endtask

  // One clock cycle: check outputs against the model, update model, advance
  task automatic step();
    int   w;
    int   g;
    logic ev;
    logic es;
    exp_t e;
    #1;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      rr_m = 0;
    end else begin
      ev = (exp_q.size() > 0) &&
           (cyc >= exp_q[0].arrive + (stall_total - exp_q[0].stall_at));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      es = ev && !rsp_ready;
      chk("div_ena", 32'(div_ena), 32'(!es));
      if (ev) begin
        chk("rsp_id",   32'(rsp_id),   32'(exp_q[0].id));
        chk("rsp_q",    32'(rsp_q),    32'(exp_q[0].r.q));
        chk("rsp_s",    32'(rsp_s),    32'(exp_q[0].r.s));
        chk("rsp_div0", 32'(rsp_div0), 32'(exp_q[0].r.div0));
        chk("rsp_ovf",  32'(rsp_ovf),  32'(exp_q[0].r.ovf));
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        acc_cnt++;
        acc_log.push_back(cyc);
        last_id = rsp_id; last_q = rsp_q; last_s = rsp_s;
        last_div0 = rsp_div0; last_ovf = rsp_ovf;
      end
      if (es) stall_total++;
      w = -1;
      if (!es) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req_valid[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
        end
      end
      chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      g = -1;
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
      if (g >= 0) grant_log.push_back(g);
      if (w >= 0) begin
        e.id = w;
        e.r = ref_div(z_in[w], d_in[w]);
        e.arrive = cyc + LAT;
        e.stall_at = stall_total;
        exp_q.push_back(e);
        rr_m = (w + 1) % NREQ;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    int n;
    int acc0;
    int stall0;
    rand_data();
    @(negedge clk);
    do_reset();
    do_reset();
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id",    32'(rsp_id),    32'd0);
    chk("reset_div_ena",   32'(div_ena),   32'd1);
    chk("reset_div_z",     32'(div_z),     32'd0);
    chk("reset_div_d",     32'(div_d),     32'd0);

    // T1 single request
    z_in[0] = 16'h1234; d_in[0] = 8'h56;
    req_valid = 4'b0001;
    step();
    drain(LAT + 2);
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_q",  32'(last_q),  32'h36);
    chk("t1_s",  32'(last_s),  32'h10);
    chk("t1_flags", {30'd0, last_div0, last_ovf}, 32'd0);

    // T2 overflow then divide-by-zero
    z_in[1] = 16'h0100; d_in[1] = 8'h01;
    req_valid = 4'b0010;
    step();
    drain(LAT + 2);
    chk("t2_ovf_id", 32'(last_id), 32'd1);
    chk("t2_ovf",    32'(last_ovf), 32'd1);
    z_in[2] = 16'h0010; d_in[2] = 8'h00;
    req_valid = 4'b0100;
    step();
    drain(LAT + 2);
    chk("t2_div0_id", 32'(last_id), 32'd2);
    chk("t2_div0",    32'(last_div0), 32'd1);

    // T3 fairness: all requesters for 8 cycles after a pointer reset
    do_reset();
    grant_log.delete();
    acc_log.delete();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step();
    end
    drain(LAT + 4);
    chk("t3_grants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("t3_grant_order", 32'(grant_log[i]), 32'(i % 4));
    chk("t3_accepts", 32'(acc_log.size()), 32'd8);
    for (int i = 1; i < 8 && i < acc_log.size(); i++)
      chk("t3_back_to_back", 32'(acc_log[i] - acc_log[i-1]), 32'd1);

    // T4 backpressure with 4 ops in flight
    do_reset();
    acc0 = acc_cnt;
    stall0 = stall_total;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
    end
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 4 * LAT) begin
      step();
      n++;
    end
    chk("t4_rsp_arrives", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (5) step();
    req_valid = '0;
    drain(LAT + 4);
    chk("t4_delivered", 32'(acc_cnt - acc0), 32'd4);
    chk("t4_stall_cycles", 32'(stall_total - stall0), 32'd5);
`ifdef DIV_SCHED_PERF_EN
    chk("t6_perf_issue", perf_issue_cnt, 32'd4);
    chk("t6_perf_stall", perf_stall_cnt, 32'd5);
`endif

    // T5 reset with 3 ops in flight
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
    end
    req_valid = '0;
    repeat (2) step();
    req_valid = 4'hF;
    do_reset();
    req_valid = '0;
    acc0 = acc_cnt;
    repeat (LAT + 2) step();
    chk("t5_no_rsp", 32'(acc_cnt - acc0), 32'd0);
    z_in[0] = 16'h1234; d_in[0] = 8'h56;
    req_valid = 4'b0001;
    step();
    drain(LAT + 2);
    chk("t5_after_id", 32'(last_id), 32'd0);
    chk("t5_after_q",  32'(last_q),  32'h36);
    chk("t5_after_s",  32'(last_s),  32'h10);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      rand_data();
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(3 * LAT);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
